chacha_stream_xor: RTL

Keystream consumer for the ChaCha20 datapath. It requests 16-word keystream blocks from the block-function core, one block per counter value, and XORs them word-by-word onto a valid/ready data stream. The same block serves encryption and decryption. It sits between the block-function core and the AEAD payload path. It owns the block counter and tells the core which counter each requested block must use.

---
 rtl/chacha_pkg.sv | 23 ++
 rtl/chacha_stream_xor_if.sv | 51 +++++
 rtl/chacha_ks_buffer.sv | 28 ++
 rtl/chacha_stream_xor.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/chacha_pkg.sv
// Shared types for the ChaCha20 keystream XOR slice.
// Optional byte-keep sideband is enabled with CHACHA_XOR_KEEP_EN.
package chacha_pkg;

  typedef logic [31:0] word_t;

  localparam int CHACHA_BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM,
    HALT
  } xor_state_t;

  function automatic word_t keep_mask(
    input logic [3:0] keep
  );
    return {{8{keep[3]}}, {8{keep[2]}},
            {8{keep[1]}}, {8{keep[0]}}};
  endfunction

endpackage

// File: rtl/chacha_stream_xor_if.sv
// Input/output word stream with valid/ready handshakes.
// Keep sideband exists only when CHACHA_XOR_KEEP_EN is defined.
interface chacha_stream_xor_if;
  import chacha_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t in_data;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  word_t out_data;
  logic  out_last;
`ifdef CHACHA_XOR_KEEP_EN
  logic [3:0] in_keep;
  logic [3:0] out_keep;
`endif

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_last,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
`ifdef CHACHA_XOR_KEEP_EN
    ,
    input  in_keep,
    output out_keep
`endif
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_last,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
`ifdef CHACHA_XOR_KEEP_EN
    ,
    output in_keep,
    input  out_keep
`endif
  );

endinterface

// File: rtl/chacha_ks_buffer.sv
// 16-word keystream capture register with word select.
// Word i of the block arrives at ks_block[i/4][i%4].
module chacha_ks_buffer
  import chacha_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  word_t [3:0][3:0]      block,
  input  logic [3:0]            sel,
  output word_t                 word
);

  // Packed layout makes flat word i equal block[i/4][i%4].
  word_t [CHACHA_BLOCK_WORDS-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mem <= '0;
    end else if (load) begin
      mem <= block;
    end
  end

  assign word = mem[sel];

endmodule

// File: rtl/chacha_stream_xor.sv
// ChaCha20 keystream consumer: requests blocks, XORs them onto a stream.
// Define CHACHA_XOR_KEEP_EN to add per-byte keep masking.
module chacha_stream_xor
  import chacha_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CTR_W-1:0]     init_counter,
  output logic                 ks_req,
  output logic [CTR_W-1:0]     ks_counter,
  input  logic                 ks_valid,
  input  word_t [3:0][3:0]     ks_block,
  chacha_stream_xor_if.slave   strm,
  output logic                 busy,
  output logic                 err_ctr_wrap
);

  xor_state_t       state;
  xor_state_t       state_nx;
  logic [CTR_W-1:0] ctr;
  logic [3:0]       idx;
  word_t            ks_word;
  word_t            res;
  logic             load;
  logic             accept;
  logic             blk_end;
  logic             ctr_max;
  logic             in_rdy;
  logic             ov_q;
  word_t            od_q;
  logic             ol_q;
  logic             err_q;
`ifdef CHACHA_XOR_KEEP_EN
  logic [3:0]       ok_q;
`endif

  chacha_ks_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .load  (load),
    .block (ks_block),
    .sel   (idx),
    .word  (ks_word)
  );

  assign load    = (state == REQ) && ks_valid && !start;
  assign in_rdy  = (state == STREAM) && (!ov_q || strm.out_ready);
  assign accept  = strm.in_valid && in_rdy;
  assign blk_end = accept && !strm.in_last && (idx == 4'hF);
  assign ctr_max = &ctr;

`ifdef CHACHA_XOR_KEEP_EN
  assign res = (strm.in_data ^ ks_word)
             & keep_mask(strm.in_keep);
`else
  assign res = strm.in_data ^ ks_word;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = REQ;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        REQ: begin
          if (ks_valid) state_nx = STREAM;
        end
        STREAM: begin
          unique case (1'b1)
            accept && strm.in_last: state_nx = IDLE;
            blk_end && ctr_max:     state_nx = HALT;
            blk_end && !ctr_max:    state_nx = REQ;
            default:                state_nx = STREAM;
          endcase
        end
        HALT:    state_nx = HALT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Start flushes the output register and clears the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr   <= '0;
      idx   <= '0;
      err_q <= 1'b0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
`ifdef CHACHA_XOR_KEEP_EN
      ok_q  <= '0;
`endif
    end else if (start) begin
      ctr   <= init_counter;
      idx   <= '0;
      err_q <= 1'b0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      ol_q  <= 1'b0;
`ifdef CHACHA_XOR_KEEP_EN
      ok_q  <= '0;
`endif
    end else begin
      if (load) idx <= '0;
      if (accept) begin
        od_q <= res;
        ol_q <= strm.in_last;
        ov_q <= 1'b1;
        idx  <= idx + 4'd1;
`ifdef CHACHA_XOR_KEEP_EN
        ok_q <= strm.in_keep;
`endif
        if (blk_end) begin
          if (ctr_max) err_q <= 1'b1;
          else         ctr   <= ctr + 1'b1;
        end
      end else if (strm.out_ready) begin
        ov_q <= 1'b0;
      end
    end
  end

  assign ks_req         = (state == REQ);
  assign ks_counter     = ctr;
  assign busy           = (state != IDLE);
  assign err_ctr_wrap   = err_q;
  assign strm.in_ready  = in_rdy;
  assign strm.out_valid = ov_q;
  assign strm.out_data  = od_q;
  assign strm.out_last  = ol_q;
`ifdef CHACHA_XOR_KEEP_EN
  assign strm.out_keep  = ok_q;
`endif

endmodule
